// File: rtl/cam_stream_emulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_pkg : sync codes and FSM state encoding shared with decoder    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package cam_pkg;

  localparam logic [7:0] CODE_FS  = 8'hAA;
  localparam logic [7:0] CODE_LS  = 8'h2A;
  localparam logic [7:0] CODE_IMG = 8'h0D;
  localparam logic [7:0] CODE_LE  = 8'h4A;
  localparam logic [7:0] CODE_FE  = 8'hCA;

  localparam int NUM_LANES = 4;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_FS   = 4'd1,
    ST_LS   = 4'd2,
    ST_IMG  = 4'd3,
    ST_DGAP = 4'd4,
    ST_DATA = 4'd5,
    ST_LE   = 4'd6,
    ST_LGAP = 4'd7,
    ST_FE   = 4'd8,
    ST_FGAP = 4'd9
  } cam_state_e;

  // Non-code states map to zero so the sync line idles low.
  function automatic logic [7:0] code_for_state(input logic [3:0] st);
    case (st)
      ST_FS:   return CODE_FS;
      ST_LS:   return CODE_LS;
      ST_IMG:  return CODE_IMG;
      ST_LE:   return CODE_LE;
      ST_FE:   return CODE_FE;
      default: return 8'h00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_stream_emulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_stream_emulator_if : serial camera sync/data bus and status    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface cam_stream_emulator_if;

  logic       enable;
  logic       cam_sync;
  logic [3:0] cam_data;
  logic       frame_active;
  logic       frame_done;
  logic [7:0] frame_cnt;

  modport master (
    input  enable,
    output cam_sync, cam_data, frame_active, frame_done, frame_cnt
  );

  modport slave (
    output enable,
    input  cam_sync, cam_data, frame_active, frame_done, frame_cnt
  );

endinterface
`default_nettype wire

// File: rtl/cam_stream_emulator_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_word_serializer : four 16-bit lanes shifted MSB first together |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cam_word_serializer
  import cam_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             load_i,
  input  logic                             shift_i,
  input  logic [NUM_LANES-1:0][15:0]       words_i,
  output logic [NUM_LANES-1:0]             bits_o,
  output logic                             last_o
);

  logic [NUM_LANES-1:0][15:0] shreg_q, shreg_d;
  logic [3:0]                 cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = words_i;
      cnt_d   = 4'd0;
    end else if (shift_i) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        shreg_d[k] = {shreg_q[k][14:0], 1'b0};
      end
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_msb
    assign bits_o[k] = shreg_q[k][15];
  end

  assign last_o = (cnt_q == 4'd15);

endmodule
`default_nettype wire

// File: rtl/cam_stream_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_stream_emulator : synthetic camera frame source, serial output |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module cam_stream_emulator
  import cam_pkg::*;
#(
  parameter int LINES     = 4,
  parameter int WORDS     = 8,
  parameter int DATA_GAP  = 2,
  parameter int LINE_GAP  = 4,
  parameter int FRAME_GAP = 16
) (
  input  logic                  cam_out_clk,
  input  logic                  reset_n,
  cam_stream_emulator_if.master cam
);

  localparam logic [3:0] S_IDLE = ST_IDLE;
  localparam logic [3:0] S_FS   = ST_FS;
  localparam logic [3:0] S_LS   = ST_LS;
  localparam logic [3:0] S_IMG  = ST_IMG;
  localparam logic [3:0] S_DGAP = ST_DGAP;
  localparam logic [3:0] S_DATA = ST_DATA;
  localparam logic [3:0] S_LE   = ST_LE;
  localparam logic [3:0] S_LGAP = ST_LGAP;
  localparam logic [3:0] S_FE   = ST_FE;
  localparam logic [3:0] S_FGAP = ST_FGAP;

  localparam logic [5:0] LINE_LAST = 6'(LINES - 1);
  localparam logic [7:0] WORD_LAST = 8'(WORDS - 1);
  localparam logic [7:0] DGAP_LAST = 8'(DATA_GAP - 1);
  localparam logic [7:0] LGAP_LAST = 8'(LINE_GAP - 1);
  localparam logic [7:0] FGAP_LAST = 8'(FRAME_GAP - 1);

  logic [3:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] word_q, word_d;
  logic [5:0] line_q, line_d;
  logic [7:0] gap_q, gap_d;

  logic       cam_sync_q, cam_sync_d;
  logic [3:0] cam_data_q, cam_data_d;
  logic       frame_active_q, frame_active_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic                       ser_load;
  logic                       ser_shift;
  logic                       ser_last;
  logic [NUM_LANES-1:0]       ser_bits;
  logic [NUM_LANES-1:0][15:0] ser_words;
  logic [7:0]                 load_word;
  logic [7:0]                 code;
  logic                       code_last;

  always_ff @(posedge cam_out_clk) begin
    assert (LINES >= 1 && LINES <= 64 && WORDS >= 1 && WORDS <= 256 &&
            DATA_GAP >= 0 && DATA_GAP <= 15 && LINE_GAP >= 1 && LINE_GAP <= 255 &&
            FRAME_GAP >= 1 && FRAME_GAP <= 255)
      else $error("cam_stream_emulator: parameter out of range");
  end

  assign code_last = (bit_cnt_q == 3'd7);
  // Word loaded at DATA entry is word 0; inside DATA it is the next word.
  assign load_word = (state_q == S_DATA) ? word_q + 8'd1 : 8'd0;
  assign ser_shift = (state_q == S_DATA);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign ser_words[k] = {2'(k), line_q, load_word};
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    line_d    = line_q;
    gap_d     = gap_q;
    ser_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cam.enable) begin
          state_d   = S_FS;
          bit_cnt_d = 3'd0;
          line_d    = 6'd0;
        end
      end
      S_FS, S_LS, S_LE, S_FE, S_IMG: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        gap_d     = 8'd0;
        if (code_last) begin
          case (state_q)
            S_FS:    state_d = S_LS;
            S_LS:    state_d = S_IMG;
            S_LE:    state_d = S_LGAP;
            S_FE:    state_d = S_FGAP;
            default: begin
              if (DATA_GAP == 0) begin
                state_d  = S_DATA;
                word_d   = 8'd0;
                ser_load = 1'b1;
              end else begin
                state_d = S_DGAP;
              end
            end
          endcase
        end
      end
      S_DGAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == DGAP_LAST) begin
          state_d  = S_DATA;
          word_d   = 8'd0;
          ser_load = 1'b1;
        end
      end
      S_DATA: begin
        if (ser_last) begin
          if (word_q == WORD_LAST) begin
            state_d   = S_LE;
            bit_cnt_d = 3'd0;
          end else begin
            word_d   = word_q + 8'd1;
            ser_load = 1'b1;
          end
        end
      end
      S_LGAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == LGAP_LAST) begin
          if (line_q == LINE_LAST) begin
            state_d = S_FE;
          end else begin
            state_d = S_LS;
            line_d  = line_q + 6'd1;
          end
        end
      end
      S_FGAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == FGAP_LAST) begin
          state_d = cam.enable ? S_FS : S_IDLE;
          line_d  = 6'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the current state and registered, so every
  // output trails the FSM by exactly one cycle.
  always_comb begin
    code           = code_for_state(state_q);
    cam_sync_d     = code[~bit_cnt_q];
    cam_data_d     = (state_q == S_DATA) ? ser_bits : 4'h0;
    frame_active_d = (state_q != S_IDLE) && (state_q != S_FGAP);
    frame_done_d   = (state_q == S_FGAP) && (gap_q == 8'd0);
    frame_cnt_d    = frame_cnt_q + {7'd0, frame_done_d};
  end

  always_ff @(posedge cam_out_clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= 3'd0;
      word_q         <= 8'd0;
      line_q         <= 6'd0;
      gap_q          <= 8'd0;
      cam_sync_q     <= 1'b0;
      cam_data_q     <= 4'h0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_cnt_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      word_q         <= word_d;
      line_q         <= line_d;
      gap_q          <= gap_d;
      cam_sync_q     <= cam_sync_d;
      cam_data_q     <= cam_data_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  cam_word_serializer u_ser (
    .clk     (cam_out_clk),
    .reset_n (reset_n),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .words_i (ser_words),
    .bits_o  (ser_bits),
    .last_o  (ser_last)
  );

  assign cam.cam_sync     = cam_sync_q;
  assign cam.cam_data     = cam_data_q;
  assign cam.frame_active = frame_active_q;
  assign cam.frame_done   = frame_done_q;
  assign cam.frame_cnt    = frame_cnt_q;

endmodule
`default_nettype wire
